// File: rtl/risc_core_param.sv
// risc_core_param: parametrised multi-cycle two-word-instruction core with a
// unified synchronous program/data memory, a program-load port and debug
// read-out of the register file.
// Optional single-step mode: define RISC_SINGLE_STEP_EN to add the step input
// and the STALL state.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | after reset, waiting for start; program port open
// F0      | memory address = pc (opcode word read in flight)
// F1      | latch opcode word into ir; address = pc+1
// F2      | latch operand word; pc += 2
// EX      | execute; LOAD presents its address and moves on to WB
// WB      | LOAD write-back of memory data into R[rd]
// HALTED  | after HALT; program port open; start restarts from pc=0
// STALL   | single-step only: wait for step after each retire
module risc_core_param #(
  parameter int DATA_W  = 8,
  parameter int REG_CNT = 4,
  parameter int ADDR_W  = 8,
  localparam int RSEL_W = $clog2(REG_CNT)
) (
  input  logic              clk,
  input  logic              reset,
`ifdef RISC_SINGLE_STEP_EN
  input  logic              step,
`endif
  input  logic              start,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_wdata,
  output logic              halted,
  output logic              retire,
  output logic [ADDR_W-1:0] pc_out,
  output logic [DATA_W-1:0] ir_out,
  output logic              zero,
  output logic              carry,
  input  logic [RSEL_W-1:0] dbg_sel,
  output logic [DATA_W-1:0] dbg_data
);

  localparam logic [3:0] OP_LOAD  = 4'd0;
  localparam logic [3:0] OP_STORE = 4'd1;
  localparam logic [3:0] OP_ADDI  = 4'd2;
  localparam logic [3:0] OP_SUBI  = 4'd3;
  localparam logic [3:0] OP_LDI   = 4'd4;
  localparam logic [3:0] OP_JZ    = 4'd5;
  localparam logic [3:0] OP_JMP   = 4'd6;
  localparam logic [3:0] OP_HALT  = 4'd7;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_F0     = 3'd1,
    S_F1     = 3'd2,
    S_F2     = 3'd3,
    S_EX     = 3'd4,
    S_WB     = 3'd5,
`ifdef RISC_SINGLE_STEP_EN
    S_HALTED = 3'd6,
    S_STALL  = 3'd7
`else
    S_HALTED = 3'd6
`endif
  } state_t;

  state_t              state, state_nx, resume_st;
  logic [ADDR_W-1:0]   pc;
  logic [DATA_W-1:0]   ir;
  logic [DATA_W-1:0]   operand;
  logic [DATA_W-1:0]   regs [REG_CNT];
  logic [DATA_W-1:0]   mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0]   mem_rdata;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic                mem_we;
  logic                port_open;

  logic [3:0]          opc;
  logic [RSEL_W-1:0]   rd;
  logic [DATA_W-1:0]   rd_val;
  logic [DATA_W:0]     add_res;
  logic [DATA_W:0]     sub_res;

  assign opc     = ir[DATA_W-1 -: 4];
  assign rd      = ir[RSEL_W-1:0];
  assign rd_val  = regs[rd];
  // The extra top bit is carry-out for the add and borrow for the subtract.
  assign add_res = {1'b0, rd_val} + {1'b0, operand};
  assign sub_res = {1'b0, rd_val} - {1'b0, operand};

  assign port_open = (state == S_IDLE) || (state == S_HALTED);

  assign halted   = (state == S_HALTED);
  assign pc_out   = pc;
  assign ir_out   = ir;
  assign dbg_data = regs[dbg_sel];

  // After a retire the core either continues fetching or parks in STALL.
  always_comb begin
`ifdef RISC_SINGLE_STEP_EN
    resume_st = S_STALL;
`else
    resume_st = S_F0;
`endif
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Next-state decode.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE,
      S_HALTED: if (start) state_nx = S_F0;
      S_F0:     state_nx = S_F1;
      S_F1:     state_nx = S_F2;
      S_F2:     state_nx = S_EX;
      S_EX: begin
        if (opc == OP_LOAD)      state_nx = S_WB;
        else if (opc == OP_HALT) state_nx = S_HALTED;
        else                     state_nx = resume_st;
      end
      S_WB:     state_nx = resume_st;
`ifdef RISC_SINGLE_STEP_EN
      S_STALL:  if (step) state_nx = S_F0;
`endif
      default:  state_nx = S_IDLE;
    endcase
  end

  // Memory port control and retire strobe; one shared address for read and write.
  always_comb begin
    mem_addr  = pc;
    mem_wdata = prog_wdata;
    mem_we    = 1'b0;
    retire    = 1'b0;
    case (state)
      S_IDLE, S_HALTED: begin
        mem_addr = prog_addr;
        mem_we   = prog_we;
      end
      S_F0: mem_addr = pc;
      S_F1: mem_addr = pc + ADDR_W'(1);
      S_EX: begin
        mem_addr = ADDR_W'(operand);
        retire   = (opc != OP_LOAD);
        if (opc == OP_STORE) begin
          mem_wdata = rd_val;
          mem_we    = 1'b1;
        end
      end
      S_WB: retire = 1'b1;
      default: ;
    endcase
    // A write coinciding with reset is dropped.
    if (reset) mem_we = 1'b0;
  end

  // Unified memory: synchronous read, write at the edge, never cleared.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  // Datapath: pc, instruction latches, register file and flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc      <= '0;
      ir      <= '0;
      operand <= '0;
      zero    <= 1'b0;
      carry   <= 1'b0;
      for (int i = 0; i < REG_CNT; i++) regs[i] <= '0;
    end else begin
      case (state)
        S_IDLE, S_HALTED: begin
          if (start) pc <= '0;
        end
        S_F1: ir <= mem_rdata;
        S_F2: begin
          operand <= mem_rdata;
          pc      <= pc + ADDR_W'(2);
        end
        S_EX: begin
          case (opc)
            OP_ADDI: begin
              regs[rd] <= add_res[DATA_W-1:0];
              carry    <= add_res[DATA_W];
              zero     <= (add_res[DATA_W-1:0] == '0);
            end
            OP_SUBI: begin
              regs[rd] <= sub_res[DATA_W-1:0];
              carry    <= sub_res[DATA_W];
              zero     <= (sub_res[DATA_W-1:0] == '0);
            end
            OP_LDI: begin
              regs[rd] <= operand;
              zero     <= (operand == '0);
            end
            OP_JZ: begin
              if (rd_val == '0) pc <= ADDR_W'(operand);
            end
            OP_JMP: pc <= ADDR_W'(operand);
            default: ;
          endcase
        end
        S_WB: begin
          regs[rd] <= mem_rdata;
          zero     <= (mem_rdata == '0);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_risc_core_param.sv
// Directed bench for risc_core_param at DATA_W=8, REG_CNT=4, ADDR_W=8.
module tb_risc_core_param;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       prog_we;
  logic [7:0] prog_addr;
  logic [7:0] prog_wdata;
  logic       halted;
  logic       retire;
  logic [7:0] pc_out;
  logic [7:0] ir_out;
  logic       zero;
  logic       carry;
  logic [1:0] dbg_sel;
  logic [7:0] dbg_data;
`ifdef RISC_SINGLE_STEP_EN
  logic       step = 1'b1;
`endif

  int n_total = 0;
  int n_bad   = 0;
  int n_ret   = 0;
  int cyc;

  risc_core_param #(.DATA_W(8), .REG_CNT(4), .ADDR_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
`ifdef RISC_SINGLE_STEP_EN
    .step       (step),
`endif
    .start      (start),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_wdata (prog_wdata),
    .halted     (halted),
    .retire     (retire),
    .pc_out     (pc_out),
    .ir_out     (ir_out),
    .zero       (zero),
    .carry      (carry),
    .dbg_sel    (dbg_sel),
    .dbg_data   (dbg_data)
  );

  always #5 clk = ~clk;

  // Retires are counted away from the active edge.
  always @(negedge clk) if (retire) n_ret++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    prog_we    = 1'b1;
    prog_addr  = a;
    prog_wdata = d;
    tick();
    prog_we    = 1'b0;
  endtask

  task automatic chk_reg(input string tag, input logic [1:0] r, input logic [7:0] exp);
    dbg_sel = r;
    #1;
    chk(tag, {24'd0, dbg_data}, {24'd0, exp});
  endtask

  // Pulse start; cycles counts clock edges including the one sampling start.
  task automatic kick;
    n_ret = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
  endtask

  task automatic wait_halt(input string tag);
    while (!halted && cyc < 300) begin
      tick();
      cyc++;
    end
    if (!halted) chk({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    prog_we    = 1'b0;
    prog_addr  = '0;
    prog_wdata = '0;
    dbg_sel    = '0;
    tick();
    tick();
    reset = 1'b0;

    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_pc", {24'd0, pc_out}, 32'h00);
    chk("rst_ir", {24'd0, ir_out}, 32'h00);
    chk("rst_flags", {30'd0, zero, carry}, 32'd0);
    chk_reg("rst_r1", 2'd1, 8'h00);

    // LDI R1,#5; ADDI R1,#2; STORE R1,[20]; HALT
    poke(8'h00, 8'h41); poke(8'h01, 8'h05); poke(8'h02, 8'h21); poke(8'h03, 8'h02);
    poke(8'h04, 8'h11); poke(8'h05, 8'h20); poke(8'h06, 8'h70); poke(8'h07, 8'h00);
    kick();
    for (int i = 0; i < 15; i++) begin tick(); cyc++; end
    chk("p1_not_yet_halted", {31'd0, halted}, 32'd0);
    wait_halt("p1");
    chk("p1_halt_cycle", cyc, 32'd17);
    chk("p1_retires", n_ret, 32'd4);
    chk_reg("p1_r1", 2'd1, 8'h07);
    chk("p1_zero", {31'd0, zero}, 32'd0);
    chk("p1_ir", {24'd0, ir_out}, 32'h70);
    chk("p1_pc", {24'd0, pc_out}, 32'h08);

    // LDI R2,#FF; ADDI R2,#1; HALT
    poke(8'h00, 8'h42); poke(8'h01, 8'hFF); poke(8'h02, 8'h22); poke(8'h03, 8'h01);
    poke(8'h04, 8'h70); poke(8'h05, 8'h00);
    kick(); wait_halt("add");
    chk_reg("add_r2", 2'd2, 8'h00);
    chk("add_carry", {31'd0, carry}, 32'd1);
    chk("add_zero", {31'd0, zero}, 32'd1);

    // LDI R3,#3; SUBI R3,#5; HALT
    poke(8'h00, 8'h43); poke(8'h01, 8'h03); poke(8'h02, 8'h33); poke(8'h03, 8'h05);
    kick(); wait_halt("sub1");
    chk_reg("sub1_r3", 2'd3, 8'hFE);
    chk("sub1_carry", {31'd0, carry}, 32'd1);
    chk("sub1_zero", {31'd0, zero}, 32'd0);

    // SUBI R3,#FE; HALT
    poke(8'h00, 8'h33); poke(8'h01, 8'hFE); poke(8'h02, 8'h70); poke(8'h03, 8'h00);
    kick(); wait_halt("sub2");
    chk_reg("sub2_r3", 2'd3, 8'h00);
    chk("sub2_carry", {31'd0, carry}, 32'd0);
    chk("sub2_zero", {31'd0, zero}, 32'd1);

    // LDI R0,#0; JZ R0,0A; HALT  with  0A: LDI R1,#AA; HALT
    poke(8'h00, 8'h40); poke(8'h01, 8'h00); poke(8'h02, 8'h50); poke(8'h03, 8'h0A);
    poke(8'h04, 8'h70); poke(8'h05, 8'h00);
    poke(8'h0A, 8'h41); poke(8'h0B, 8'hAA); poke(8'h0C, 8'h70); poke(8'h0D, 8'h00);
    kick(); wait_halt("jz_taken");
    chk_reg("jz_taken_r1", 2'd1, 8'hAA);
    chk("jz_taken_pc", {24'd0, pc_out}, 32'h0E);
    chk("jz_taken_retires", n_ret, 32'd4);

    // LDI R0,#1; JZ R0,0A; LDI R1,#11; HALT
    poke(8'h01, 8'h01); poke(8'h04, 8'h41); poke(8'h05, 8'h11);
    poke(8'h06, 8'h70); poke(8'h07, 8'h00);
    kick();
    for (int i = 0; i < 9; i++) begin tick(); cyc++; end
    chk("jz_fall_pc", {24'd0, pc_out}, 32'h04);
    wait_halt("jz_fall");
    chk_reg("jz_fall_r1", 2'd1, 8'h11);
    chk("jz_fall_pc_end", {24'd0, pc_out}, 32'h08);

    // 00: SUBI R3,#70; 02: JMP FF; FF: LDI R1,<mem[0]=33>; 01: HALT
    poke(8'h80, 8'h12);
    poke(8'h00, 8'h33); poke(8'h01, 8'h70); poke(8'h02, 8'h60); poke(8'h03, 8'hFF);
    poke(8'hFF, 8'h41);
    kick();
    tick(); cyc++;
    prog_we = 1'b1; prog_addr = 8'h80; prog_wdata = 8'h5A;
    tick(); cyc++;
    prog_we = 1'b0;
    wait_halt("wrap");
    chk_reg("wrap_r1", 2'd1, 8'h33);
    chk_reg("wrap_r3", 2'd3, 8'h90);
    chk("wrap_pc", {24'd0, pc_out}, 32'h03);
    chk("wrap_carry", {31'd0, carry}, 32'd1);

    // LDI R1,#55; STORE R1,[30] with reset landing on the STORE's EX cycle
    poke(8'h30, 8'h99);
    poke(8'h00, 8'h41); poke(8'h01, 8'h55); poke(8'h02, 8'h11); poke(8'h03, 8'h30);
    kick();
    for (int i = 0; i < 7; i++) tick();
    chk("st_ex_retire", {31'd0, retire}, 32'd1);
    chk("st_ex_ir", {24'd0, ir_out}, 32'h11);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_halted", {31'd0, halted}, 32'd0);
    chk("mid_rst_retire", {31'd0, retire}, 32'd0);
    chk("mid_rst_pc", {24'd0, pc_out}, 32'h00);
    chk("mid_rst_ir", {24'd0, ir_out}, 32'h00);
    chk("mid_rst_flags", {30'd0, zero, carry}, 32'd0);
    chk_reg("mid_rst_r1", 2'd1, 8'h00);
    chk_reg("mid_rst_r3", 2'd3, 8'h00);

    // LOAD R2,[30]; LOAD R3,[80]; LOAD R0,[20]; HALT
    poke(8'h00, 8'h02); poke(8'h01, 8'h30); poke(8'h02, 8'h03); poke(8'h03, 8'h80);
    poke(8'h04, 8'h00); poke(8'h05, 8'h20); poke(8'h06, 8'h70); poke(8'h07, 8'h00);
    kick(); wait_halt("ld");
    chk("ld_halt_cycle", cyc, 32'd20);
    chk("ld_retires", n_ret, 32'd4);
    chk_reg("ld_store_suppressed", 2'd2, 8'h99);
    chk_reg("ld_prog_we_ignored", 2'd3, 8'h12);
    chk_reg("ld_p1_store", 2'd0, 8'h07);
    chk("ld_zero", {31'd0, zero}, 32'd0);
    chk("ld_pc", {24'd0, pc_out}, 32'h08);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
